control_plane_block: RTL and testbench

CONTROL_PLANE_BLOCK -- requirements
Module: control_plane

---
 rtl/control_plane_block.sv | 245 ++++++++++++++++++++++++
 tb/tb_control_plane_block.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_plane_block.sv
// Control plane sequencer: loads state/config/inbound tables from the phit stream, then walks
// the per-column config pointer during a run. Define PIPE_SKEW_EN to delay column c outputs by c cycles.
//   state    | meaning
//   IDLE     | waiting for start_loader
//   PREP     | two settle cycles, counters cleared
//   LD_STATE | two state words, word 0 carries run_length
//   LD_CFG   | 6*N config beats, column-major
//   LD_INB   | M inbound RF beats, RF write enable driven
//   READY    | loaded, waiting for stream valid
//   RUN      | stepping seg/ptr per accepted beat
module control_plane_block #(
    parameter int phit_size     = 512,
    parameter int sz_config     = 24,
    parameter int num_col       = 6,
    parameter int dwidth_double = 64,
    parameter int dwidth_RFadd  = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [phit_size-1:0]               wr_data,
    input  logic                               start_loader,
    input  logic                               start_stream_in,
    input  logic [dwidth_RFadd-1:0]            num_entry_config_table,
    input  logic [dwidth_RFadd-1:0]            num_entry_inbound,
    output logic [sz_config*num_col-1:0]       rd_data_ctrl,
    output logic [phit_size*num_col-1:0]       rd_data_imm,
    output logic [dwidth_double*num_col-1:0]   itr,
    output logic                               ready_stream_in,
    output logic                               wr_en_RF_runtimeLoadTable,
    output logic [dwidth_RFadd-1:0]            wr_add_RF_runtimeLoadTable
);

    localparam int AW    = dwidth_RFadd;
    localparam int Depth = 2 ** dwidth_RFadd;
    localparam int ColW  = (num_col > 1) ? $clog2(num_col) : 1;
    localparam int ImmW  = 64;

    typedef enum logic [2:0] {
        S_IDLE, S_PREP, S_LD_STATE, S_LD_CFG, S_LD_INB, S_READY, S_RUN
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       n_cfg_q, n_cfg_d;
    logic [AW-1:0]       n_inb_q, n_inb_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic [ColW-1:0]     col_q, col_d;
    logic [AW-1:0]       ptr_q, ptr_d;
    logic [31:0]         run_len_q, run_len_d;
    logic [31:0]         seg_q, seg_d;
    logic [dwidth_double-1:0] itr_q, itr_d;
    logic                cfg_we;
    logic [31:0]         run_len_eff;
    logic [47:0]         state_word;
    logic                out_en;
    logic                unused_bits;

    logic [sz_config-1:0] ctrl_mem [num_col][Depth];
    logic [ImmW-1:0]      imm_mem  [num_col][Depth];

    assign state_word  = wr_data[phit_size-1 -: 48];
    assign run_len_eff = (run_len_q == 32'd0) ? 32'd1 : run_len_q;
    assign out_en      = (state_q == S_RUN) && (n_cfg_q != '0);
    assign unused_bits = ^{wr_data[phit_size-49:ImmW], state_word[47:32]};

    always_comb begin
        state_d   = state_q;
        n_cfg_d   = n_cfg_q;
        n_inb_d   = n_inb_q;
        cnt_d     = cnt_q;
        col_d     = col_q;
        ptr_d     = ptr_q;
        run_len_d = run_len_q;
        seg_d     = seg_q;
        itr_d     = itr_q;
        cfg_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_loader) begin
                    state_d = S_PREP;
                    n_cfg_d = num_entry_config_table;
                    n_inb_d = num_entry_inbound;
                    cnt_d   = '0;
                    col_d   = '0;
                    ptr_d   = '0;
                    seg_d   = '0;
                    itr_d   = '0;
                end
            end
            S_PREP: begin
                if (cnt_q == AW'(1)) begin
                    state_d = S_LD_STATE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            S_LD_STATE: begin
                if (cnt_q == '0) begin
                    run_len_d = state_word[31:0];
                    cnt_d     = AW'(1);
                end else begin
                    cnt_d = '0;
                    col_d = '0;
                    if (n_cfg_q != '0)      state_d = S_LD_CFG;
                    else if (n_inb_q != '0) state_d = S_LD_INB;
                    else                    state_d = S_READY;
                end
            end
            S_LD_CFG: begin
                cfg_we = 1'b1;
                if (cnt_q == n_cfg_q - AW'(1)) begin
                    cnt_d = '0;
                    if (col_q == ColW'(num_col - 1)) begin
                        col_d   = '0;
                        state_d = (n_inb_q != '0) ? S_LD_INB : S_READY;
                    end else begin
                        col_d = col_q + ColW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            S_LD_INB: begin
                if (cnt_q == n_inb_q - AW'(1)) begin
                    cnt_d   = '0;
                    state_d = S_READY;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            S_READY: begin
                if (start_stream_in) begin
                    state_d = S_RUN;
                    seg_d   = run_len_eff - 32'd1;
                    ptr_d   = '0;
                    itr_d   = '0;
                end
            end
            S_RUN: begin
                // Last entry gets exactly one beat, then the run drains back to IDLE.
                if (start_stream_in) begin
                    itr_d = itr_q + dwidth_double'(1);
                    if ((n_cfg_q == '0) || (ptr_q == n_cfg_q - AW'(1))) begin
                        state_d = S_IDLE;
                    end else if (seg_q == 32'd0) begin
                        seg_d = run_len_eff - 32'd1;
                        ptr_d = ptr_q + AW'(1);
                    end else begin
                        seg_d = seg_q - 32'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            n_cfg_q   <= '0;
            n_inb_q   <= '0;
            cnt_q     <= '0;
            col_q     <= '0;
            ptr_q     <= '0;
            run_len_q <= '0;
            seg_q     <= '0;
            itr_q     <= '0;
        end else begin
            state_q   <= state_d;
            n_cfg_q   <= n_cfg_d;
            n_inb_q   <= n_inb_d;
            cnt_q     <= cnt_d;
            col_q     <= col_d;
            ptr_q     <= ptr_d;
            run_len_q <= run_len_d;
            seg_q     <= seg_d;
            itr_q     <= itr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (cfg_we) begin
            ctrl_mem[col_q][cnt_q] <= wr_data[phit_size-1 -: sz_config];
            imm_mem[col_q][cnt_q]  <= wr_data[ImmW-1:0];
        end
    end

    assign ready_stream_in            = (state_q == S_RUN);
    assign wr_en_RF_runtimeLoadTable  = (state_q == S_LD_INB);
    assign wr_add_RF_runtimeLoadTable = (state_q == S_LD_INB) ? cnt_q : '0;

    for (genvar c = 0; c < num_col; c++) begin : g_col
        logic [sz_config-1:0] ctrl_c;
        logic [phit_size-1:0] imm_c;

        always_comb begin
            ctrl_c = '0;
            imm_c  = '0;
            if (out_en) begin
                ctrl_c           = ctrl_mem[c][ptr_q];
                imm_c[ImmW-1:0]  = imm_mem[c][ptr_q];
            end
        end

`ifdef PIPE_SKEW_EN
        if (c == 0) begin : g_direct
            assign rd_data_ctrl[c*sz_config +: sz_config]  = ctrl_c;
            assign rd_data_imm[c*phit_size +: phit_size]   = imm_c;
            assign itr[c*dwidth_double +: dwidth_double]   = itr_q;
        end else begin : g_skew
            logic [sz_config-1:0]     ctrl_sk_q [c];
            logic [phit_size-1:0]     imm_sk_q  [c];
            logic [dwidth_double-1:0] itr_sk_q  [c];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < c; i++) begin
                        ctrl_sk_q[i] <= '0;
                        imm_sk_q[i]  <= '0;
                        itr_sk_q[i]  <= '0;
                    end
                end else begin
                    ctrl_sk_q[0] <= ctrl_c;
                    imm_sk_q[0]  <= imm_c;
                    itr_sk_q[0]  <= itr_q;
                    for (int i = 1; i < c; i++) begin
                        ctrl_sk_q[i] <= ctrl_sk_q[i-1];
                        imm_sk_q[i]  <= imm_sk_q[i-1];
                        itr_sk_q[i]  <= itr_sk_q[i-1];
                    end
                end
            end

            assign rd_data_ctrl[c*sz_config +: sz_config]  = ctrl_sk_q[c-1];
            assign rd_data_imm[c*phit_size +: phit_size]   = imm_sk_q[c-1];
            assign itr[c*dwidth_double +: dwidth_double]   = itr_sk_q[c-1];
        end
`else
        assign rd_data_ctrl[c*sz_config +: sz_config]  = ctrl_c;
        assign rd_data_imm[c*phit_size +: phit_size]   = imm_c;
        assign itr[c*dwidth_double +: dwidth_double]   = itr_q;
`endif
    end

endmodule

// File: tb/tb_control_plane_block.sv
// Scoreboard bench for control_plane_block: expected RF addresses and run outputs are queued
// as stimulus is driven and checked by a negedge monitor.
module tb_control_plane_block;

    localparam int PS = 512;
    localparam int SC = 24;
    localparam int NC = 6;
    localparam int DD = 64;
    localparam int AW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [PS-1:0]     wr_data;
    logic              start_loader;
    logic              start_stream_in;
    logic [AW-1:0]     num_entry_config_table;
    logic [AW-1:0]     num_entry_inbound;
    logic [SC*NC-1:0]  rd_data_ctrl;
    logic [PS*NC-1:0]  rd_data_imm;
    logic [DD*NC-1:0]  itr;
    logic              ready_stream_in;
    logic              wr_en;
    logic [AW-1:0]     wr_add;

    control_plane_block dut (
        .clk                        (clk),
        .rst                        (rst),
        .wr_data                    (wr_data),
        .start_loader               (start_loader),
        .start_stream_in            (start_stream_in),
        .num_entry_config_table     (num_entry_config_table),
        .num_entry_inbound          (num_entry_inbound),
        .rd_data_ctrl               (rd_data_ctrl),
        .rd_data_imm                (rd_data_imm),
        .itr                        (itr),
        .ready_stream_in            (ready_stream_in),
        .wr_en_RF_runtimeLoadTable  (wr_en),
        .wr_add_RF_runtimeLoadTable (wr_add)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] c0;
        logic [23:0] c3;
        logic [63:0] imm2;
        logic [63:0] itr0;
    } run_exp_t;

    run_exp_t    run_q[$];
    logic [7:0]  wr_q[$];
    int          n_vec = 0;
    int          n_miss = 0;
    int          wr_cnt = 0;
    int          cyc_n = 0;
    int          t0 = -1;
    int          t5 = -1;
    logic [23:0] ctrl_tab1 [6] = '{24'h880000, 24'h880000, 24'h800000, 24'h900004, 24'hA00000, 24'h900000};

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] ctrl_val(input int ld, input int c, input int e);
        if (ld == 0) return (e == 1) ? ctrl_tab1[c] : 24'h0;
        if (ld == 1) return 24'h100000 | 24'(c << 8) | 24'(e);
        return 24'h300000 | 24'(c << 8) | 24'(e);
    endfunction

    function automatic logic [63:0] imm_val(input int ld, input int c, input int e);
        return 64'hC0DE_0000_0000_0000 | 64'(ld << 16) | 64'(c << 8) | 64'(e);
    endfunction

    function automatic run_exp_t mk_exp(input int ld, input int n, input int b, input int rle);
        run_exp_t x;
        int e;
        x.c0 = '0; x.c3 = '0; x.imm2 = '0;
        x.itr0 = 64'(b);
        if (n > 0) begin
            e = b / rle;
            if (e > n - 1) e = n - 1;
            x.c0   = ctrl_val(ld, 0, e);
            x.c3   = ctrl_val(ld, 3, e);
            x.imm2 = imm_val(ld, 2, e);
        end
        return x;
    endfunction

    always @(negedge clk) begin : mon
        run_exp_t x;
        cyc_n++;
        if (wr_en === 1'b1) begin
            wr_cnt++;
            if (wr_q.size() != 0) chk_eq("wr_add", 64'(wr_add), 64'(wr_q.pop_front()));
            else                  chk_eq("wr_en_unexpected", 64'(wr_en), 64'd0);
        end
        if (ready_stream_in === 1'b1) begin
            if (run_q.size() != 0) begin
                x = run_q.pop_front();
                chk_eq("run_ctrl0", 64'(rd_data_ctrl[0 +: SC]), 64'(x.c0));
                chk_eq("run_itr0", itr[0 +: DD], x.itr0);
`ifndef PIPE_SKEW_EN
                chk_eq("run_ctrl3", 64'(rd_data_ctrl[3*SC +: SC]), 64'(x.c3));
                chk_eq("run_imm2", rd_data_imm[2*PS +: 64], x.imm2);
                chk_eq("run_imm2_hi", 64'(|rd_data_imm[2*PS+64 +: PS-64]), 64'd0);
`endif
            end else begin
                chk_eq("ready_unexpected", 64'(ready_stream_in), 64'd0);
            end
        end
        if (t0 < 0 && itr[0 +: DD] == 64'd16) t0 = cyc_n;
        if (t5 < 0 && itr[5*DD +: DD] == 64'd16) t5 = cyc_n;
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_cfg(input int ld, input int c, input int e);
        wr_data = '0;
        wr_data[PS-1 -: SC] = ctrl_val(ld, c, e);
        wr_data[63:0] = imm_val(ld, c, e);
        wr_data[300 +: 32] = $urandom();
    endtask

    task automatic load_head(input int n, input int m, input logic [31:0] rl);
        cyc();
        start_loader = 1'b1;
        num_entry_config_table = AW'(n);
        num_entry_inbound = AW'(m);
        cyc();
        start_loader = 1'b0;
        num_entry_config_table = 8'hFF;
        num_entry_inbound = 8'hFF;
        wr_data = {16{$urandom()}};
        cyc();
        wr_data = {16{$urandom()}};
        cyc();
        wr_data = '0;
        wr_data[PS-1 -: 48] = {16'h8000, rl};
        cyc();
        wr_data = {16{$urandom()}};
    endtask

    task automatic do_load(input int ld, input int n, input int m, input logic [31:0] rl);
        int w0;
        w0 = wr_cnt;
        load_head(n, m, rl);
        for (int c = 0; c < NC; c++) begin
            for (int e = 0; e < n; e++) begin
                cyc();
                drive_cfg(ld, c, e);
            end
        end
        for (int j = 0; j < m; j++) begin
            cyc();
            wr_data = {16{$urandom()}};
            wr_q.push_back(8'(j));
        end
        cyc();
        chk_eq("ready_before_run", 64'(ready_stream_in), 64'd0);
        chk_eq("wr_en_cycles", 64'(wr_cnt - w0), 64'(m));
    endtask

    task automatic do_run(input int ld, input int n, input logic [31:0] rl, input int stall_at);
        int b, nst, rle, e;
        bit done;
        b = 0; nst = 0; done = 0;
        rle = (rl == 0) ? 1 : int'(rl);
        start_stream_in = 1'b1;
        while (!done) begin
            cyc();
            run_q.push_back(mk_exp(ld, n, b, rle));
            if (b == stall_at && nst < 5) begin
                start_stream_in = 1'b0;
                nst++;
            end else begin
                start_stream_in = 1'b1;
                e = b / rle;
                if (n == 0 || e >= n - 1) done = 1;
                b++;
            end
        end
        cyc();
        start_stream_in = 1'b0;
        repeat (6) cyc();
        chk_eq("post_run_ready", 64'(ready_stream_in), 64'd0);
        chk_eq("post_run_itr0", itr[0 +: DD], 64'(b));
        chk_eq("post_run_itr5", itr[5*DD +: DD], 64'(b));
        chk_eq("post_run_ctrl", 64'(|rd_data_ctrl), 64'd0);
        chk_eq("post_run_imm", 64'(|rd_data_imm), 64'd0);
        chk_eq("run_queue_left", 64'(run_q.size()), 64'd0);
    endtask

    initial begin
        int w0;
        rst = 1'b1;
        wr_data = '0;
        start_loader = 1'b0;
        start_stream_in = 1'b1;
        num_entry_config_table = '0;
        num_entry_inbound = '0;
        repeat (3) cyc();
        chk_eq("rst_ready", 64'(ready_stream_in), 64'd0);
        chk_eq("rst_wr_en", 64'(wr_en), 64'd0);
        chk_eq("rst_wr_add", 64'(wr_add), 64'd0);
        chk_eq("rst_ctrl", 64'(|rd_data_ctrl), 64'd0);
        chk_eq("rst_imm", 64'(|rd_data_imm), 64'd0);
        chk_eq("rst_itr", 64'(|itr), 64'd0);
        rst = 1'b0;
        repeat (4) cyc();
        chk_eq("idle_ready", 64'(ready_stream_in), 64'd0);
        start_stream_in = 1'b0;

        do_load(0, 2, 16, 32'h10);
        t0 = -1; t5 = -1;
        do_run(0, 2, 32'h10, 8);
`ifdef PIPE_SKEW_EN
        chk_eq("itr_skew_col5", 64'(t5 - t0), 64'd5);
`endif

        w0 = wr_cnt;
        load_head(2, 4, 32'd3);
        for (int k = 0; k < 3; k++) begin
            cyc();
            drive_cfg(9, k / 2, k % 2);
        end
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk_eq("abort_ready", 64'(ready_stream_in), 64'd0);
        chk_eq("abort_wr_en", 64'(wr_en), 64'd0);
        chk_eq("abort_itr", itr[0 +: DD], 64'd0);
        start_stream_in = 1'b1;
        repeat (3) cyc();
        start_stream_in = 1'b0;
        chk_eq("abort_no_wr", 64'(wr_cnt - w0), 64'd0);

        do_load(1, 3, 3, 32'd0);
        do_run(1, 3, 32'd0, -1);

        do_load(2, 0, 0, 32'd5);
        do_run(2, 0, 32'd5, -1);

        chk_eq("wr_queue_left", 64'(wr_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
